// File: rtl/bcd_convert_seq.sv
// rtl/bcd_convert_seq.sv - sequential binary-to-BCD converter (shift-and-add-3)
//
// Converts an unsigned BIN_W-bit value into DIGITS packed BCD digits, one
// shift per clock with every digit adjusted in parallel. The result is held
// on o_BCD between conversions and updated only on the o_Valid edge.
//
// Optional build macro: BCD_CONVERT_SEQ_BLANK_EN enables the leading-zero
// blank mask on o_Blank; without it o_Blank is tied low.
//
// Ports:
//   i_Clock    system clock
//   i_Reset    synchronous active-high reset
//   i_Start    request a conversion of i_Binary (sampled only while idle)
//   i_Binary   unsigned value to convert
//   o_Busy     conversion in progress
//   o_Valid    one-cycle pulse: o_BCD / o_Overflow / o_Blank just updated
//   o_BCD      result, digit k in bits [4k+3:4k]
//   o_Overflow last result did not fit in DIGITS digits
//   o_Blank    leading-zero blank mask (bit 0 never set)
module bcd_convert_seq #(
  parameter int BIN_W      = 12,
  parameter int DIGITS     = 4,
  parameter int AUTO_START = 0
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Start,
  input  logic [BIN_W-1:0]      i_Binary,
  output logic                  o_Busy,
  output logic                  o_Valid,
  output logic [4*DIGITS-1:0]   o_BCD,
  output logic                  o_Overflow,
  output logic [DIGITS-1:0]     o_Blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [BIN_W-1:0]   bin_sh;
  logic [BIN_W-1:0]   last_bin;
  logic [BCD_W-1:0]   work;
  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_nxt;
  logic               ovf_acc;
  logic               ovf_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               trigger;
  logic               last_shift;

  // Auto-start compares against the value last latched, not the last output,
  // so a value that is converting is not re-triggered when the FSM goes idle.
  assign trigger    = i_Start || ((AUTO_START != 0) && (i_Binary != last_bin));
  assign last_shift = (cnt == CNT_W'(BIN_W - 1));
  assign o_Busy     = (state == S_SHIFT);

  // Add-3 on every digit >= 5, no carry between digits, then shift the
  // binary MSB into digit 0. The bit leaving the top digit is overflow.
  always_comb begin
    work_adj = work;
    for (int k = 0; k < DIGITS; k++) begin
      if (work[4*k +: 4] >= 4'd5) begin
        work_adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
      end
    end
    work_nxt = {work_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
    ovf_nxt  = ovf_acc | work_adj[BCD_W-1];
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trigger)    state_nxt = S_SHIFT;
      S_SHIFT: if (last_shift) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef BCD_CONVERT_SEQ_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic              zero_above;

  // Walk down from the top digit; a digit blanks only while every digit
  // above it is also zero. Digit 0 always shows so a value of 0 reads "0".
  always_comb begin
    blank_nxt  = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above   = zero_above & (work_nxt[4*k +: 4] == 4'd0);
      blank_nxt[k] = zero_above;
    end
    if (ovf_nxt) begin
      blank_nxt = '0;
    end
  end
`else
  assign o_Blank = '0;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      bin_sh     <= '0;
      last_bin   <= '0;
      work       <= '0;
      ovf_acc    <= 1'b0;
      cnt        <= '0;
      o_Valid    <= 1'b0;
      o_BCD      <= '0;
      o_Overflow <= 1'b0;
`ifdef BCD_CONVERT_SEQ_BLANK_EN
      o_Blank    <= '0;
`endif
    end else begin
      o_Valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            bin_sh   <= i_Binary;
            last_bin <= i_Binary;
            work     <= '0;
            ovf_acc  <= 1'b0;
            cnt      <= '0;
          end
        end
        S_SHIFT: begin
          bin_sh  <= bin_sh << 1;
          work    <= work_nxt;
          ovf_acc <= ovf_nxt;
          cnt     <= cnt + CNT_W'(1);
          if (last_shift) begin
            o_BCD      <= work_nxt;
            o_Overflow <= ovf_nxt;
            o_Valid    <= 1'b1;
`ifdef BCD_CONVERT_SEQ_BLANK_EN
            o_Blank    <= blank_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// tb/tb_bcd_convert_seq.sv - self-checking bench for bcd_convert_seq
module tb_bcd_convert_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: defaults; dut1: DIGITS=3; dut2: AUTO_START=1
  logic        rst0, start0, busy0, valid0, ovf0;
  logic [11:0] bin0;
  logic [15:0] bcd0;
  logic [3:0]  blank0;

  logic        rst12, start1, busy1, valid1, ovf1;
  logic [11:0] bin1;
  logic [11:0] bcd1;
  logic [2:0]  blank1;

  logic        start2, busy2, valid2, ovf2;
  logic [11:0] bin2;
  logic [15:0] bcd2;
  logic [3:0]  blank2;

  bcd_convert_seq dut0 (
    .i_Clock(clk), .i_Reset(rst0), .i_Start(start0), .i_Binary(bin0),
    .o_Busy(busy0), .o_Valid(valid0), .o_BCD(bcd0), .o_Overflow(ovf0), .o_Blank(blank0)
  );

  bcd_convert_seq #(.BIN_W(12), .DIGITS(3), .AUTO_START(0)) dut1 (
    .i_Clock(clk), .i_Reset(rst12), .i_Start(start1), .i_Binary(bin1),
    .o_Busy(busy1), .o_Valid(valid1), .o_BCD(bcd1), .o_Overflow(ovf1), .o_Blank(blank1)
  );

  bcd_convert_seq #(.BIN_W(12), .DIGITS(4), .AUTO_START(1)) dut2 (
    .i_Clock(clk), .i_Reset(rst12), .i_Start(start2), .i_Binary(bin2),
    .o_Busy(busy2), .o_Valid(valid2), .o_BCD(bcd2), .o_Overflow(ovf2), .o_Blank(blank2)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int n_starts0 = 0;
  int valids0 = 0;
  logic [15:0] held0 = '0;
  logic        rst0_q = 1'b0;

  function automatic logic [39:0] model_bcd(int v, int digits);
    logic [39:0] r;
    r = '0;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(int v, int digits);
    int lim;
    lim = 1;
    for (int k = 0; k < digits; k++) lim = lim * 10;
    return (v >= lim);
  endfunction

  function automatic logic [9:0] model_blank(int v, int digits);
    logic [9:0] b;
    logic       za;
    int         p;
    b = '0;
`ifdef BCD_CONVERT_SEQ_BLANK_EN
    if (!model_ovf(v, digits)) begin
      za = 1'b1;
      for (int k = digits - 1; k >= 1; k--) begin
        p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        za = za & (((v / p) % 10) == 0);
        b[k] = za;
      end
    end
`else
    za = 1'b0;
    p  = 0;
`endif
    return b;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor for dut0: every o_Valid pops one expected value;
  // outside valid cycles o_BCD must hold the last result.
  always @(posedge clk) rst0_q <= rst0;

  always @(negedge clk) begin
    int          v;
    logic [39:0] eb;
    logic [9:0]  ebl;
    if (rst0_q) begin
      held0 = '0;
    end else if (valid0) begin
      valids0++;
      check("busy_low_in_valid", busy0, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1'b1, 1'b0);
      end else begin
        v   = exp_q.pop_front();
        eb  = model_bcd(v, 4);
        ebl = model_blank(v, 4);
        check("bcd0", bcd0, eb[15:0]);
        check("ovf0", ovf0, model_ovf(v, 4));
        check("blank0", blank0, ebl[3:0]);
      end
      held0 = bcd0;
    end else begin
      check("bcd0_hold", bcd0, held0);
    end
  end

  task automatic start_dut0(int v);
    bin0   = 12'(v);
    start0 = 1'b1;
    exp_q.push_back(v);
    n_starts0++;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_valid(int which, int max_cycles, string tag);
    logic seen;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = valid0;
        1:       seen = valid1;
        default: seen = valid2;
      endcase
      if (seen) return;
    end
    check({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic count_valid2(int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid2) n++;
    end
  endtask

  initial begin
    int nbusy, first_v, nv;
    int bl_vals[4];
    logic [3:0] bl_exp[4];

    rst0 = 1'b1; rst12 = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    bin0 = '0; bin1 = '0; bin2 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy0, 1'b0);
    check("rst_valid", valid0, 1'b0);
    check("rst_bcd", bcd0, 16'h0000);
    check("rst_ovf", ovf0, 1'b0);
    check("rst_blank", blank0, 4'b0000);
    rst0 = 1'b0; rst12 = 1'b0;
    @(negedge clk);

    // Latency: busy 12 cycles, valid in cycle t0+13.
    bin0 = 12'd4095; start0 = 1'b1; exp_q.push_back(4095); n_starts0++;
    @(posedge clk);
    nbusy = 0; first_v = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start0 = 1'b0;
      if (busy0) nbusy++;
      if (valid0 && first_v == 0) first_v = i;
    end
    check("busy_cycles", 32'(nbusy), 32'd12);
    check("valid_latency", 32'(first_v), 32'd13);
    check("bcd_4095", bcd0, 16'h4095);

    // Full sweep, back-to-back starts in each valid cycle.
    for (int v = 0; v < 4096; v++) begin
      start_dut0(v);
      wait_valid(0, 20, "sweep");
    end
    repeat (3) @(negedge clk);
    check("sweep_valid_count", 32'(valids0), 32'(n_starts0));
    check("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

    // Start while busy is ignored.
    start_dut0(5);
    repeat (3) @(negedge clk);
    bin0 = 12'd77; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_valid(0, 20, "busy_ignore");
    check("busy_ignore_bcd", bcd0, 16'h0005);
    repeat (20) @(negedge clk);
    check("busy_ignore_count", 32'(valids0), 32'(n_starts0));

    // Reset mid-shift aborts without a valid pulse.
    bin0 = 12'd123; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    check("abort_busy", busy0, 1'b0);
    check("abort_valid", valid0, 1'b0);
    check("abort_bcd", bcd0, 16'h0000);
    check("abort_ovf", ovf0, 1'b0);
    rst0 = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_valid", 32'(valids0), 32'(n_starts0));

    // Leading-zero blanking (expected mask is zero when the feature is off).
    bl_vals[0] = 7;    bl_vals[1] = 0;    bl_vals[2] = 1050; bl_vals[3] = 60;
`ifdef BCD_CONVERT_SEQ_BLANK_EN
    bl_exp[0] = 4'b1110; bl_exp[1] = 4'b1110; bl_exp[2] = 4'b0000; bl_exp[3] = 4'b1100;
`else
    bl_exp[0] = 4'b0000; bl_exp[1] = 4'b0000; bl_exp[2] = 4'b0000; bl_exp[3] = 4'b0000;
`endif
    for (int i = 0; i < 4; i++) begin
      start_dut0(bl_vals[i]);
      wait_valid(0, 20, "blank");
      check("blank_lit", blank0, bl_exp[i]);
    end

    // DIGITS=3: overflow keeps value mod 1000.
    bin1 = 12'd1234; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_valid(1, 20, "d3_1234");
    check("d3_1234_bcd", bcd1, 12'h234);
    check("d3_1234_ovf", ovf1, 1'b1);
    check("d3_1234_blank", blank1, 3'b000);
    bin1 = 12'd999; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_valid(1, 20, "d3_999");
    check("d3_999_bcd", bcd1, 12'h999);
    check("d3_999_ovf", ovf1, 1'b0);
    bin1 = 12'd1000; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_valid(1, 20, "d3_1000");
    check("d3_1000_bcd", bcd1, 12'h000);
    check("d3_1000_ovf", ovf1, 1'b1);

    // AUTO_START: conversion on input change only.
    count_valid2(10, nv);
    check("auto_idle_count", 32'(nv), 32'd0);
    bin2 = 12'd300;
    wait_valid(2, 20, "auto_300");
    check("auto_300_bcd", bcd2, 16'h0300);
    count_valid2(50, nv);
    check("auto_hold_count", 32'(nv), 32'd0);
    bin2 = 12'd301;
    wait_valid(2, 20, "auto_301");
    check("auto_301_bcd", bcd2, 16'h0301);
    count_valid2(20, nv);
    check("auto_after_count", 32'(nv), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
